// File: rtl/bus_select_arbiter.sv
// Round-robin arbiter for a 4-source tri-state bus with parked turnaround.
// Define BUS_ARB_HOLD_LIMIT_EN to enable the MAX_HOLD tenure limit and timeout.
module bus_select_arbiter #(
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:2] s,
    output logic       enable,
    output logic       timeout
);
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] turn_cnt;
    logic       pick_vld;
    logic [1:0] pick;
    logic       owner_req;
    logic       hold_done;
    logic       arb_now;

    // Descending scan so the index nearest ptr is the one left standing.
    always_comb begin
        pick_vld = 1'b0;
        pick     = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (req[ptr + 2'(j)]) begin
                pick_vld = 1'b1;
                pick     = ptr + 2'(j);
            end
        end
    end

    assign owner_req = req[s];

    always_comb begin
        arb_now = 1'b0;
        if (pick_vld) begin
            arb_now = (state == IDLE) ||
                      ((state == TURN) && (turn_cnt == TURN_LAST));
        end
    end

`ifdef BUS_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_PRE  = 8'(MAX_HOLD - 2);

    logic [7:0] hold_cnt;

    assign hold_done = (hold_cnt == HOLD_LAST);

    // Timeout is raised one edge early so it lines up with the last grant cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state != GRANT) begin
                hold_cnt <= 8'd0;
            end else if (owner_req && !hold_done) begin
                if (hold_cnt != 8'hFF) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
                timeout <= (hold_cnt == HOLD_PRE);
            end
        end
    end
`else
    assign hold_done = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'd0;
            s        <= 2'd0;
            enable   <= 1'b0;
            ptr      <= 2'd0;
            turn_cnt <= 4'd0;
        end else if (arb_now) begin
            state  <= GRANT;
            gnt    <= 4'b0001 << pick;
            s      <= pick;
            enable <= 1'b1;
            ptr    <= pick + 2'd1;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= IDLE;
                end
                GRANT: begin
                    if (!owner_req || hold_done) begin
                        state    <= TURN;
                        gnt      <= 4'd0;
                        enable   <= 1'b0;
                        turn_cnt <= 4'd0;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
